mpm_request_scheduler: RTL and testbench

Round-robin scheduler that shares the PORTS physical ports of the multi-ported LVT memory among REQS requesters (REQS ≥ PORTS). Each cycle it grants up to PORTS valid requests, drives them onto the memory port arrays, and routes read data back to the originating requester one cycle later. It sits between client engines and the memory, and is the only driver of the memory's addr/en/d arrays.

---
 rtl/mpm_request_scheduler.sv | 102 ++++++++++
 tb/tb_mpm_request_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpm_request_scheduler.sv
// Round-robin scheduler sharing PORTS memory ports among REQS requesters; routes read data back one cycle later.
// Optional: define MPM_SCHED_WCONFLICT_EN to defer same-address writes within one grant scan.
module mpm_request_scheduler #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int PORTS = 4,
  parameter int REQS  = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int RW   = $clog2(REQS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQS-1:0]      req_valid,
  input  logic [REQS-1:0]      req_write,
  input  logic [AW-1:0]        req_addr  [REQS],
  input  logic [WIDTH-1:0]     req_wdata [REQS],
  output logic [REQS-1:0]      req_ready,
  output logic [REQS-1:0]      rsp_valid,
  output logic [WIDTH-1:0]     rsp_data  [REQS],
  output logic [AW-1:0]        mem_addr  [PORTS],
  output logic [PORTS-1:0]     mem_en,
  output logic [WIDTH-1:0]     mem_d     [PORTS],
  input  logic [WIDTH-1:0]     mem_q     [PORTS]
);

  logic [RW-1:0]    rr_reg, rr_next;
  logic [REQS-1:0]  grant;
  logic [PORTS-1:0] port_busy;
  logic [RW-1:0]    port_src [PORTS];
  logic [PORTS-1:0] tag_valid_reg;
  logic [RW-1:0]    tag_req_reg [PORTS];

  // Scan from rr; each accepted request takes the lowest free port.
  always_comb begin
    int cnt;
    grant     = '0;
    port_busy = '0;
    rr_next   = rr_reg;
    cnt       = 0;
    for (int p = 0; p < PORTS; p++) port_src[p] = '0;
    for (int i = 0; i < REQS; i++) begin
      int   ri;
      logic blocked;
      ri      = (int'(rr_reg) + i) % REQS;
      blocked = 1'b0;
`ifdef MPM_SCHED_WCONFLICT_EN
      for (int p = 0; p < PORTS; p++) begin
        if (port_busy[p] && req_write[port_src[p]] && req_write[ri] &&
            req_addr[port_src[p]] == req_addr[ri])
          blocked = 1'b1;
      end
`endif
      if (!rst && req_valid[ri] && cnt < PORTS && !blocked) begin
        port_busy[cnt] = 1'b1;
        port_src[cnt]  = RW'(ri);
        grant[ri]      = 1'b1;
        rr_next        = (ri == REQS - 1) ? '0 : RW'(ri + 1);
        cnt++;
      end
    end
  end

  assign req_ready = grant;

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      assign mem_addr[gi] = port_busy[gi] ? req_addr[port_src[gi]]  : '0;
      assign mem_d[gi]    = port_busy[gi] ? req_wdata[port_src[gi]] : '0;
      assign mem_en[gi]   = port_busy[gi] & req_write[port_src[gi]];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg        <= '0;
      tag_valid_reg <= '0;
      for (int p = 0; p < PORTS; p++) tag_req_reg[p] <= '0;
    end else begin
      rr_reg <= rr_next;
      for (int p = 0; p < PORTS; p++) begin
        tag_valid_reg[p] <= port_busy[p] & ~req_write[port_src[p]];
        tag_req_reg[p]   <= port_src[p];
      end
    end
  end

  // Each requester owns at most one tag, so the OR-free overwrite below is unambiguous.
  always_comb begin
    rsp_valid = '0;
    for (int r = 0; r < REQS; r++) rsp_data[r] = '0;
    for (int r = 0; r < REQS; r++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (tag_valid_reg[p] && tag_req_reg[p] == RW'(r)) begin
          rsp_valid[r] = 1'b1;
          rsp_data[r]  = mem_q[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_mpm_request_scheduler.sv
// Bench for mpm_request_scheduler: behavioural memory plus a list-based arbitration model checked every cycle.
module tb_mpm_request_scheduler;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int PORTS = 4;
  localparam int REQS  = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic [REQS-1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [AW-1:0]    req_addr  [REQS];
  logic [WIDTH-1:0] req_wdata [REQS];
  logic [WIDTH-1:0] rsp_data  [REQS];
  logic [AW-1:0]    mem_addr  [PORTS];
  logic [PORTS-1:0] mem_en;
  logic [WIDTH-1:0] mem_d     [PORTS];
  logic [WIDTH-1:0] mem_q     [PORTS];

  int checks = 0;
  int errors = 0;

  mpm_request_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory the scheduler drives: registered read, read-before-write, later port wins.
  logic [WIDTH-1:0] mem [DEPTH];
  initial for (int a = 0; a < DEPTH; a++) mem[a] = '0;
  always @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) mem_q[p] <= mem[mem_addr[p]];
    for (int p = 0; p < PORTS; p++) if (mem_en[p]) mem[mem_addr[p]] <= mem_d[p];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int               m_rr = 0;
  bit               m_rsp_valid [REQS];
  logic [WIDTH-1:0] m_rsp_data  [REQS];
  logic [WIDTH-1:0] m_mem       [DEPTH];
  initial begin
    for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    for (int r = 0; r < REQS; r++) begin m_rsp_valid[r] = 0; m_rsp_data[r] = '0; end
  end

  always begin : compare
    int               n, last, rr_nx;
    logic [REQS-1:0]  e_ready, e_rsp_valid;
    logic [PORTS-1:0] e_en;
    logic [AW-1:0]    e_addr [PORTS];
    logic [WIDTH-1:0] e_d    [PORTS];
    bit               nx_valid [REQS];
    logic [WIDTH-1:0] nx_data  [REQS];
    int               wr_addrs [$];
    @(negedge clk);
    e_ready = '0; e_en = '0; n = 0; last = 0;
    wr_addrs.delete();
    for (int p = 0; p < PORTS; p++) begin e_addr[p] = '0; e_d[p] = '0; end
    for (int r = 0; r < REQS; r++) begin nx_valid[r] = 0; nx_data[r] = '0; end
    if (!rst) begin
      for (int i = 0; i < REQS; i++) begin
        int r;
        bit dup;
        r   = (m_rr + i) % REQS;
        dup = 0;
`ifdef MPM_SCHED_WCONFLICT_EN
        foreach (wr_addrs[k]) if (req_write[r] && wr_addrs[k] == int'(req_addr[r])) dup = 1;
`endif
        if (req_valid[r] && n < PORTS && !dup) begin
          e_ready[r] = 1'b1;
          e_addr[n]  = req_addr[r];
          e_d[n]     = req_wdata[r];
          e_en[n]    = req_write[r];
          if (req_write[r]) wr_addrs.push_back(int'(req_addr[r]));
          else begin nx_valid[r] = 1; nx_data[r] = m_mem[req_addr[r]]; end
          last = r;
          n++;
        end
      end
    end
    rr_nx = (n > 0) ? (last + 1) % REQS : m_rr;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("mem_en", 64'(mem_en), 64'(e_en));
    for (int p = 0; p < PORTS; p++) begin
      chk($sformatf("mem_addr[%0d]", p), 64'(mem_addr[p]), 64'(e_addr[p]));
      chk($sformatf("mem_d[%0d]", p), 64'(mem_d[p]), 64'(e_d[p]));
    end
    for (int r = 0; r < REQS; r++) e_rsp_valid[r] = !rst && m_rsp_valid[r];
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
    for (int r = 0; r < REQS; r++)
      chk($sformatf("rsp_data[%0d]", r), 64'(rsp_data[r]), e_rsp_valid[r] ? 64'(m_rsp_data[r]) : 64'd0);
    if (n > 0 || e_rsp_valid != '0)
      $display("t=%0t rr=%0d grant=%b wen=%b rsp=%b", $time, m_rr, e_ready, e_en, e_rsp_valid);
    @(posedge clk);
    if (rst) begin
      m_rr = 0;
      for (int r = 0; r < REQS; r++) m_rsp_valid[r] = 0;
    end else begin
      m_rr = rr_nx;
      for (int p = 0; p < n; p++) if (e_en[p]) m_mem[e_addr[p]] = e_d[p];
      for (int r = 0; r < REQS; r++) begin m_rsp_valid[r] = nx_valid[r]; m_rsp_data[r] = nx_data[r]; end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_check();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_write = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    for (int r = 0; r < REQS; r++) begin req_addr[r] = AW'(100 + r); req_wdata[r] = '0; end
    #1 rst = 1'b1;
    req_valid = '1;
    at_check();
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_mem_en", 64'(mem_en), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    next_cycle();
    rst = 1'b0;

    // All-valid reads: grant sets alternate halves.
    for (int c = 0; c < 4; c++) begin
      at_check();
      chk($sformatf("rr_ready_c%0d", c), 64'(req_ready), (c % 2 == 0) ? 64'h0F : 64'hF0);
      if (c == 0) chk("rr_first_addr", 64'(mem_addr[0]), 64'd100);
      next_cycle();
    end

    // Write then read back through another requester.
    idle();
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = AW'(5); req_wdata[2] = 32'hDEADBEEF;
    at_check();
    chk("wr_ready", 64'(req_ready), 64'h04);
    next_cycle();
    idle();
    req_valid[6] = 1'b1; req_addr[6] = AW'(5);
    at_check();
    chk("rd_ready", 64'(req_ready), 64'h40);
    next_cycle();
    idle();
    at_check();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h40);
    chk("rd_rsp_data", 64'(rsp_data[6]), 64'hDEADBEEF);
    next_cycle();

    // Sparse: steer rr to 3, then a lone request 7 lands on port 0.
    req_valid = 8'h05; req_addr[0] = AW'(20); req_addr[2] = AW'(21);
    at_check();
    chk("sparse_setup", 64'(req_ready), 64'h05);
    next_cycle();
    req_valid = 8'h80; req_addr[7] = AW'(22);
    at_check();
    chk("sparse_ready", 64'(req_ready), 64'h80);
    chk("sparse_port0", 64'(mem_addr[0]), 64'd22);
    next_cycle();
    req_valid = 8'h81; req_addr[0] = AW'(23);
    at_check();
    chk("sparse_rr0_port0", 64'(mem_addr[0]), 64'd23);
    chk("sparse_rr0_port1", 64'(mem_addr[1]), 64'd22);
    next_cycle();

    // Two writes to one address from rr = 0.
    idle();
    req_valid = 8'h03; req_write = 8'h03;
    req_addr[0] = AW'(9); req_addr[1] = AW'(9);
    req_wdata[0] = 32'h11111111; req_wdata[1] = 32'h22222222;
    at_check();
`ifdef MPM_SCHED_WCONFLICT_EN
    chk("conflict_first", 64'(req_ready), 64'h01);
    next_cycle();
    req_valid = 8'h02;
    at_check();
    chk("conflict_second", 64'(req_ready), 64'h02);
`else
    chk("conflict_both", 64'(req_ready), 64'h03);
`endif
    next_cycle();

    // Reset while a read is in flight.
    idle();
    req_valid[4] = 1'b1; req_addr[4] = AW'(5);
    at_check();
    chk("midrst_ready", 64'(req_ready), 64'h10);
    rst = 1'b1;
    next_cycle();
    chk("midrst_rsp_in_reset", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    idle();
    at_check();
    chk("midrst_rsp_after", 64'(rsp_valid), 64'd0);
    next_cycle();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < REQS; r++) begin
        req_valid[r] = ($urandom_range(0, 9) < 6);
        req_write[r] = ($urandom_range(0, 9) < 4);
        req_wdata[r] = $urandom;
`ifdef MPM_SCHED_WCONFLICT_EN
        req_addr[r] = req_write[r] ? AW'(16 + $urandom_range(0, 3)) : AW'(16 + $urandom_range(0, 15));
`else
        req_addr[r] = req_write[r] ? AW'(16 + 2 * r + $urandom_range(0, 1)) : AW'(16 + $urandom_range(0, 15));
`endif
      end
      next_cycle();
    end
    rst = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
